// File: rtl/levels_streamer.sv
// levels_streamer: captures one macroblock's quantised levels and modes on a
// one-cycle strobe, then streams them out as 256-bit beats over a valid/ready
// port: header, optional luma DC (intra16 only), 16 luma blocks, 8 chroma
// blocks. The last chroma beat carries out_last.
// Build option: define LEVELS_STREAMER_SKIP_EN to emit only a header beat
// (with out_last set) for skipped macroblocks.
module levels_streamer (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [255:0]  dc_levels,
    input  logic [4095:0] ac_levels,
    input  logic [2047:0] uv_levels,
    input  logic [7:0]    mbtype,
    input  logic [7:0]    skipped,
    input  logic [31:0]   nz,
    input  logic [31:0]   mode_i16,
    input  logic [127:0]  mode_i4,
    input  logic [31:0]   mode_uv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_type,
    output logic [4:0]    out_idx,
    output logic [255:0]  out_coeffs,
    output logic          out_nz,
    output logic          out_last,
    output logic          busy,
    output logic          overflow
);

`ifdef LEVELS_STREAMER_SKIP_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DC   = 3'd2,
        ST_Y    = 3'd3,
        ST_UV   = 3'd4
    } state_t;

    localparam logic [1:0] T_HDR = 2'd0;
    localparam logic [1:0] T_DC  = 2'd1;
    localparam logic [1:0] T_Y   = 2'd2;
    localparam logic [1:0] T_UV  = 2'd3;

    state_t          state_q;
    logic            out_valid_q;
    logic [1:0]      out_type_q;
    logic [4:0]      out_idx_q;
    logic [255:0]    out_coeffs_q;
    logic            out_nz_q;
    logic            out_last_q;
    logic            overflow_q;
    logic [255:0]    dc_q;
    logic [4095:0]   ac_q;
    logic [2047:0]   uv_q;
    logic            intra16_q;
    logic [31:0]     nz_q;

    logic            start_s;
    logic            adv_s;
    logic [4:0]      idx_next_s;
    logic            unused_s;

    // Header word built straight from the input buses at capture time.
    function automatic logic [255:0] hdr_payload(
        input logic [127:0] m_i4,
        input logic [7:0]   m_i16,
        input logic [7:0]   m_uv,
        input logic         intra16,
        input logic         skip,
        input logic [31:0]  nzf
    );
        hdr_payload = {78'd0, nzf, skip, intra16, m_uv, m_i16, m_i4};
    endfunction

    // Luma block selector, block b at bits [256b+255:256b].
    function automatic logic [255:0] y_block(input logic [4095:0] ac, input logic [3:0] b);
        y_block = ac[{b, 8'd0} +: 256];
    endfunction

    // Chroma block selector, block b at bits [256b+255:256b].
    function automatic logic [255:0] uv_block(input logic [2047:0] uv, input logic [2:0] b);
        uv_block = uv[{b, 8'd0} +: 256];
    endfunction

    // Handshake qualifiers; a new MB may be taken while idle or while the final beat leaves.
    always_comb begin
        in_ready   = (state_q == ST_IDLE) || (out_valid_q && out_ready && out_last_q);
        start_s    = in_valid && in_ready;
        adv_s      = out_valid_q && out_ready;
        idx_next_s = out_idx_q + 5'd1;
    end

    assign out_valid  = out_valid_q;
    assign out_type   = out_type_q;
    assign out_idx    = out_idx_q;
    assign out_coeffs = out_coeffs_q;
    assign out_nz     = out_nz_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != ST_IDLE);
    assign overflow   = overflow_q;
    assign unused_s   = ^{mbtype[7:1], mode_i16[31:8], mode_uv[31:8]};

    // Sequencer: capture, beat advance and registered output payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_type_q   <= 2'd0;
            out_idx_q    <= 5'd0;
            out_coeffs_q <= 256'd0;
            out_nz_q     <= 1'b0;
            out_last_q   <= 1'b0;
            overflow_q   <= 1'b0;
            dc_q         <= 256'd0;
            ac_q         <= 4096'd0;
            uv_q         <= 2048'd0;
            intra16_q    <= 1'b0;
            nz_q         <= 32'd0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow_q <= 1'b1;
            end
            if (start_s) begin
                dc_q         <= dc_levels;
                ac_q         <= ac_levels;
                uv_q         <= uv_levels;
                intra16_q    <= mbtype[0];
                nz_q         <= nz;
                state_q      <= ST_HDR;
                out_valid_q  <= 1'b1;
                out_type_q   <= T_HDR;
                out_idx_q    <= 5'd0;
                out_coeffs_q <= hdr_payload(mode_i4, mode_i16[7:0], mode_uv[7:0],
                                            mbtype[0], (skipped != 8'd0), nz);
                out_nz_q     <= 1'b0;
                out_last_q   <= SKIP_EN && (skipped != 8'd0);
            end else if (adv_s) begin
                if (out_last_q) begin
                    state_q      <= ST_IDLE;
                    out_valid_q  <= 1'b0;
                    out_type_q   <= 2'd0;
                    out_idx_q    <= 5'd0;
                    out_coeffs_q <= 256'd0;
                    out_nz_q     <= 1'b0;
                    out_last_q   <= 1'b0;
                end else begin
                    case (state_q)
                        ST_HDR: begin
                            if (intra16_q) begin
                                state_q      <= ST_DC;
                                out_type_q   <= T_DC;
                                out_idx_q    <= 5'd24;
                                out_coeffs_q <= dc_q;
                                out_nz_q     <= nz_q[24];
                            end else begin
                                state_q      <= ST_Y;
                                out_type_q   <= T_Y;
                                out_idx_q    <= 5'd0;
                                out_coeffs_q <= y_block(ac_q, 4'd0);
                                out_nz_q     <= nz_q[0];
                            end
                        end
                        ST_DC: begin
                            state_q      <= ST_Y;
                            out_type_q   <= T_Y;
                            out_idx_q    <= 5'd0;
                            out_coeffs_q <= y_block(ac_q, 4'd0);
                            out_nz_q     <= nz_q[0];
                        end
                        ST_Y: begin
                            if (out_idx_q == 5'd15) begin
                                state_q      <= ST_UV;
                                out_type_q   <= T_UV;
                                out_idx_q    <= 5'd16;
                                out_coeffs_q <= uv_block(uv_q, 3'd0);
                                out_nz_q     <= nz_q[16];
                            end else begin
                                out_idx_q    <= idx_next_s;
                                out_coeffs_q <= y_block(ac_q, idx_next_s[3:0]);
                                out_nz_q     <= nz_q[idx_next_s];
                            end
                        end
                        ST_UV: begin
                            out_idx_q    <= idx_next_s;
                            out_coeffs_q <= uv_block(uv_q, idx_next_s[2:0]);
                            out_nz_q     <= nz_q[idx_next_s];
                            out_last_q   <= (idx_next_s == 5'd23);
                        end
                        default: begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_levels_streamer.sv
// Bench for levels_streamer: randomized macroblocks, a reference beat list
// built from the stream format, and a negedge monitor that pops a scoreboard.
module tb_levels_streamer;

`ifdef LEVELS_STREAMER_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [255:0]  dc_levels;
    logic [4095:0] ac_levels;
    logic [2047:0] uv_levels;
    logic [7:0]    mbtype, skipped;
    logic [31:0]   nz, mode_i16, mode_uv;
    logic [127:0]  mode_i4;
    logic          out_valid, out_ready;
    logic [1:0]    out_type;
    logic [4:0]    out_idx;
    logic [255:0]  out_coeffs;
    logic          out_nz, out_last, busy, overflow;

    always #5 clk = ~clk;

    levels_streamer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dc_levels(dc_levels), .ac_levels(ac_levels), .uv_levels(uv_levels),
        .mbtype(mbtype), .skipped(skipped), .nz(nz), .mode_i16(mode_i16),
        .mode_i4(mode_i4), .mode_uv(mode_uv), .out_valid(out_valid),
        .out_ready(out_ready), .out_type(out_type), .out_idx(out_idx),
        .out_coeffs(out_coeffs), .out_nz(out_nz), .out_last(out_last),
        .busy(busy), .overflow(overflow)
    );

    typedef struct {
        logic [1:0]   t;
        logic [4:0]   idx;
        logic [255:0] c;
        logic         nzf;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int total = 0;
    int bad = 0;
    int mon_beats = 0;
    int exp_n = 0;
    int ready_mode = 0;
    bit stall_prev = 1'b0;
    logic [264:0] held;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ready();
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_ready();
    endtask

    task automatic rand_mb();
        for (int i = 0; i < 128; i++) ac_levels[i*32 +: 32] = $urandom();
        for (int i = 0; i < 64; i++) uv_levels[i*32 +: 32] = $urandom();
        for (int i = 0; i < 8; i++) dc_levels[i*32 +: 32] = $urandom();
        for (int i = 0; i < 4; i++) mode_i4[i*32 +: 32] = $urandom();
        mbtype   = 8'($urandom());
        skipped  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        nz       = $urandom();
        mode_i16 = $urandom();
        mode_uv  = $urandom();
    endtask

    // Expected beat list for the MB currently on the input buses.
    task automatic model_push();
        beat_t b;
        logic [255:0] hdr;
        bit single;
        hdr = '0;
        hdr[127:0]   = mode_i4;
        hdr[135:128] = mode_i16[7:0];
        hdr[143:136] = mode_uv[7:0];
        hdr[144]     = mbtype[0];
        hdr[145]     = (skipped != 8'd0);
        hdr[177:146] = nz;
        single = SKIP_EN && (skipped != 8'd0);
        b.t = 2'd0; b.idx = 5'd0; b.c = hdr; b.nzf = 1'b0; b.last = single;
        exp_q.push_back(b);
        exp_n = 1;
        if (!single) begin
            if (mbtype[0]) begin
                b.t = 2'd1; b.idx = 5'd24; b.c = dc_levels; b.nzf = nz[24]; b.last = 1'b0;
                exp_q.push_back(b);
                exp_n++;
            end
            for (int i = 0; i < 16; i++) begin
                b.t = 2'd2; b.idx = 5'(i); b.c = ac_levels[i*256 +: 256]; b.nzf = nz[i]; b.last = 1'b0;
                exp_q.push_back(b);
                exp_n++;
            end
            for (int j = 0; j < 8; j++) begin
                b.t = 2'd3; b.idx = 5'(16 + j); b.c = uv_levels[j*256 +: 256];
                b.nzf = nz[16 + j]; b.last = (j == 7);
                exp_q.push_back(b);
                exp_n++;
            end
        end
    endtask

    // One-cycle strobe; the model accepts only when idle or on the final handshake.
    task automatic send();
        in_valid = 1'b1;
        if (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready && exp_q[0].last))
            model_push();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL timeout: %0d beats still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_beat(input logic [1:0] t, input logic [4:0] i);
        bit found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            if (out_valid && out_type == t && out_idx == i) found = 1'b1;
            else tick();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_beat: beat type %0d idx %0d never seen", t, i);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Monitor: pop and compare on every handshake, check stability while stalled.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (out_ready) begin
                total++;
                mon_beats++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat: got type=%0d idx=%0d, required no beat", out_type, out_idx);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (out_type !== e.t || out_idx !== e.idx || out_coeffs !== e.c ||
                        out_nz !== e.nzf || out_last !== e.last) begin
                        bad++;
                        $display("FAIL beat: got t=%0d i=%0d nz=%0d last=%0d c=%h required t=%0d i=%0d nz=%0d last=%0d c=%h",
                                 out_type, out_idx, out_nz, out_last, out_coeffs,
                                 e.t, e.idx, e.nzf, e.last, e.c);
                    end
                end
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    total++;
                    if ({out_type, out_idx, out_coeffs, out_nz, out_last} !== held) begin
                        bad++;
                        $display("FAIL stall_hold: got %h required %h",
                                 {out_type, out_idx, out_coeffs, out_nz, out_last}, held);
                    end
                end
                held = {out_type, out_idx, out_coeffs, out_nz, out_last};
                stall_prev = 1'b1;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        dc_levels = '0; ac_levels = '0; uv_levels = '0; mbtype = '0; skipped = '0;
        nz = '0; mode_i16 = '0; mode_i4 = '0; mode_uv = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_payload", {out_type, out_idx, out_nz, out_last, out_coeffs}, '0);
        tick();

        // Intra16 directed MB, always ready.
        ready_mode = 0;
        rand_mb();
        mbtype = 8'h01; skipped = 8'd0; nz = 32'h0100_0008;
        ac_levels[3*256 +: 256] = {16{16'h0005}};
        mon_beats = 0;
        send();
        check("hdr_after_capture", {out_valid, out_type}, {1'b1, 2'd0});
        check("busy_active", busy, 1'b1);
        wait_done();
        check("intra16_beats", 32'(mon_beats), 32'd26);

        // Intra4 directed MB with out_ready toggling.
        ready_mode = 1;
        rand_mb();
        mbtype = 8'h00; skipped = 8'd0;
        mode_i4 = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
        mon_beats = 0;
        send();
        wait_done();
        check("intra4_beats", 32'(mon_beats), 32'd25);

        // Skipped intra16 MB.
        ready_mode = 0;
        rand_mb();
        mbtype = 8'h01; skipped = 8'd1;
        mon_beats = 0;
        send();
        wait_done();
        check("skipped_beats", 32'(mon_beats), SKIP_EN ? 32'd1 : 32'd26);

        // Randomized MBs with random backpressure.
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            int want;
            rand_mb();
            mon_beats = 0;
            send();
            want = exp_n;
            wait_done();
            check("rand_beats", 32'(mon_beats), 32'(want));
        end

        // Input during Y idx 7 is dropped and flagged.
        ready_mode = 0;
        tick();
        rand_mb();
        skipped = 8'd0;
        send();
        wait_beat(2'd2, 5'd7);
        rand_mb();
        send();
        check("overflow_set", overflow, 1'b1);
        wait_done();
        repeat (10) tick();
        check("overflow_sticky", overflow, 1'b1);
        check("idle_after_drop", busy, 1'b0);

        do_reset();
        check("overflow_cleared", overflow, 1'b0);

        // Back-to-back capture on the final handshake.
        ready_mode = 0;
        rand_mb();
        skipped = 8'd0;
        send();
        for (int n = 0; n < 100 && exp_q.size() > 1; n++) tick();
        rand_mb();
        check("b2b_in_ready", in_ready, 1'b1);
        send();
        check("b2b_header", {out_valid, out_type, out_idx}, {1'b1, 2'd0, 5'd0});
        check("b2b_no_overflow", overflow, 1'b0);
        wait_done();

        // Reset in the middle of the chroma beats.
        rand_mb();
        skipped = 8'd0;
        send();
        wait_beat(2'd3, 5'd18);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_overflow", overflow, 1'b0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        repeat (10) tick();
        check("midrst_idle", {busy, out_valid}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/levels_streamer.md
LEVELS_STREAMER -- requirements
Module: levels_streamer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have in_valid  in  1  one-cycle macroblock-result strobe (the decimation stage's done).
REQ-003 SHALL have in_ready  out  1  high in IDLE, or in the cycle the final beat handshakes.
REQ-004 SHALL have dc_levels  in  256  luma DC (Y2) levels, 16 x 16-bit.
REQ-005 SHALL have ac_levels  in  4096  16 luma blocks, block i at bits [256i+255:256i].
REQ-006 SHALL have uv_levels  in  2048  8 chroma blocks (U 0-3, V 4-7), block j at bits [256j+255:256j].
REQ-007 SHALL have mbtype  in  8  bit0=1 intra16, 0 intra4; skipped  in  8  nonzero means skipped MB; nz  in  32  non-zero flags (bits 0-15 Y, 16-23 UV, 24 DC).
REQ-008 SHALL have mode_i16  in  32, mode_i4  in  128, mode_uv  in  32  prediction modes.
REQ-009 SHALL have out_valid  out  1, out_ready  in  1  valid/ready output handshake.
REQ-010 SHALL have out_type  out  2  0 header, 1 DC, 2 Y, 3 UV; out_idx  out  5  block index; out_coeffs  out  256  payload; out_nz  out  1  block non-zero flag; out_last  out  1  final beat of MB.
REQ-011 SHALL have busy  out  1  state != IDLE; overflow  out  1  sticky dropped-input flag.

Function
REQ-012 in_valid with in_ready high SHALL register all input buses in that cycle; in_valid with in_ready low SHALL be ignored and SHALL set overflow.
REQ-013 States: IDLE, HDR, DC, Y, UV; capture moves IDLE->HDR; header out_valid SHALL rise the cycle after capture.
REQ-014 A beat advances only on out_valid && out_ready; while out_valid is high and out_ready is low, all out_* SHALL hold stable.
REQ-015 Sequence: HDR (idx 0); if mbtype[0]: DC (idx 24); Y idx 0..15; UV idx 16..23; out_last on UV idx 23; HDR->Y directly when mbtype[0]=0.
REQ-016 Beat counts: 26 for intra16, 25 for intra4 (full mode).
REQ-017 Header payload: [127:0]=mode_i4, [135:128]=mode_i16[7:0], [143:136]=mode_uv[7:0], [144]=mbtype[0], [145]=(skipped!=0), [177:146]=nz, [255:178]=0; header out_nz=0.
REQ-018 DC beat: out_coeffs=dc_levels, out_nz=nz[24]; Y beat idx i: ac_levels block i, out_nz=nz[i]; UV beat idx 16+j: uv_levels block j, out_nz=nz[16+j].
REQ-019 Final-beat handshake SHALL go to IDLE, or to HDR if in_valid is high in that same cycle (back-to-back, no bubble, no overflow).
REQ-020 out_valid SHALL be low in IDLE; out_coeffs bits not defined by REQ-017/018 SHALL be 0.

Reset
REQ-021 On rst_n low: state IDLE, out_valid=0, out_type=0, out_idx=0, out_coeffs=0, out_nz=0, out_last=0, busy=0, overflow=0, captured registers=0; in_ready=1 after release.
REQ-022 Reset mid-MB SHALL abandon the MB immediately; no further beats from it after release.

Configuration
REQ-023 Macro LEVELS_STREAMER_SKIP_EN defined: when captured skipped!=0, only the header beat SHALL be emitted, with out_last=1, then IDLE.
REQ-024 Macro undefined: skipped MBs SHALL emit the full sequence of REQ-015; header bit 145 still reflects skipped.

Verification
REQ-025 Intra16, out_ready=1, ac block 3 = all 0x0005, nz=0x0100_0008 -> 26 beats: HDR, DC(idx24,nz=1), Y0..15 (idx3 coeffs 0x0005, nz=1), UV16..23, last on beat 26.
REQ-026 Intra4, mode_i4=0x0123..., out_ready toggling 1/0 each cycle -> 25 beats, header[127:0]=mode_i4, payload stable during every stall cycle.
REQ-027 in_valid during Y idx 7 -> overflow=1, current MB completes unchanged, second MB not emitted.
REQ-028 in_valid on final-beat handshake cycle -> next cycle header of new MB, overflow=0.
REQ-029 SKIP_EN defined, skipped=1 -> single header beat, out_last=1, bit145=1; undefined -> 26/25 beats.
REQ-030 rst_n low during UV idx 18 -> out_valid=0 next edge, busy=0, overflow=0, in_ready=1 after release.
